// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ producers.
// Define UART_TX_ARB_TIMEOUT_EN to add the WAIT_ACK watchdog and sticky err flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           grant_idx,
    output logic                 err
);
    localparam int               GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]       NREQ4    = 4'(NUM_REQ);
    localparam logic [2:0]       PTR_RST  = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         ptr, ptr_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic [NUM_REQ-1:0] ack_nx;
    logic               tx_start_nx;
    logic [7:0]         tx_data_nx;
    logic               busy_nx;
    logic [2:0]         grant_nx;
    logic               err_nx;

    logic [7:0]         req_pad;
    logic [63:0]        data_pad;
    logic [3:0]         pos;
    logic [2:0]         winner;
    logic               found;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [WD_W-1:0] wd_cnt, wd_nx;
`else
    // The watchdog limit only matters in the timeout build.
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Round-robin search starting just after the last winner, wrapping at NUM_REQ.
    always_comb begin
        req_pad  = 8'(req);
        data_pad = 64'(req_data);
        found    = 1'b0;
        winner   = ptr;
        pos      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= NREQ4) pos = pos - NREQ4;
            if (!found && req_pad[pos[2:0]]) begin
                found  = 1'b1;
                winner = pos[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (found) state_nx = S_START;
            S_START:     state_nx = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx_done) state_nx = S_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) state_nx = S_IDLE;
`endif
            end
            S_WAIT_DONE: if (!tx_done) state_nx = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:       if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the grant is taken on the IDLE->START edge.
    always_comb begin
        ack_nx      = '0;
        tx_start_nx = 1'b0;
        tx_data_nx  = tx_data;
        grant_nx    = grant_idx;
        ptr_nx      = ptr;
        gap_cnt_nx  = '0;
        busy_nx     = (state_nx != S_IDLE);
        if (state == S_IDLE && found) begin
            ack_nx      = NUM_REQ'(1) << winner;
            tx_start_nx = 1'b1;
            tx_data_nx  = data_pad[{winner, 3'b000} +: 8];
            grant_nx    = winner;
            ptr_nx      = winner;
        end
        if (state == S_GAP && state_nx == S_GAP) gap_cnt_nx = gap_cnt + GAP_W'(1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_nx  = (state == S_WAIT_ACK && state_nx == S_WAIT_ACK) ? wd_cnt + WD_W'(1) : '0;
        err_nx = err | (state == S_WAIT_ACK && state_nx == S_IDLE);
`else
        err_nx = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            grant_idx <= 3'd0;
            err       <= 1'b0;
            ptr       <= PTR_RST;
            gap_cnt   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            ack       <= ack_nx;
            tx_start  <= tx_start_nx;
            tx_data   <= tx_data_nx;
            busy      <= busy_nx;
            grant_idx <= grant_nx;
            err       <= err_nx;
            ptr       <= ptr_nx;
            gap_cnt   <= gap_cnt_nx;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt    <= wd_nx;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued when requests are
// driven and compared when tx_start appears.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int GAP_CYCLES     = 16;
    localparam int TIMEOUT_CYCLES = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done = 1'b0;
    logic                 busy;
    logic [2:0]           grant_idx;
    logic                 err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .grant_idx(grant_idx),
        .err(err)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] bytes[8];
    logic [2:0] m_ptr;
    logic       prev_start = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    always_comb req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] pick(input logic [NUM_REQ-1:0] r, input logic [2:0] p);
        logic [7:0] rp;
        logic [2:0] k;
        rp = 8'(r);
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = 3'((int'(p) + i) % NUM_REQ);
            if (rp[k]) return k;
        end
        return p;
    endfunction

    task automatic push_exp(input logic [NUM_REQ-1:0] r);
        logic [2:0] w;
        w = pick(r, m_ptr);
        exp_q.push_back({w, bytes[w]});
        m_ptr = w;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 60);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
    endtask

    task automatic xmit(input int lat, input int len);
        repeat (lat) @(negedge clk);
        tx_done = 1'b1;
        repeat (len) @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        req     = '0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_ack"},   32'(ack), 0);
        check_eq({tag, "_start"}, 32'(tx_start), 0);
        check_eq({tag, "_data"},  32'(tx_data), 0);
        check_eq({tag, "_grant"}, 32'(grant_idx), 0);
        check_eq({tag, "_err"},   32'(err), 0);
        rst   = 1'b0;
        m_ptr = 3'(NUM_REQ - 1);
    endtask

    task automatic run_frames(input logic [NUM_REQ-1:0] r, input int cnt, input string tag);
        int n;
        req = r;
        for (int k = 0; k < cnt; k++) begin
            push_exp(r);
            wait_start(n);
            check_eq({tag, "_lat"}, 32'(n), 1);
            if (k == cnt - 1) req = '0;
            xmit(1, 3);
            wait_idle(n);
            check_eq({tag, "_gap"}, 32'(n), GAP_CYCLES + 1);
        end
    endtask

    // Every start pulse is matched against the oldest queued grant.
    always @(negedge clk) begin : monitor
        exp_t               e;
        logic [NUM_REQ-1:0] oh;
        if (tx_start) begin
            check_eq("start_pulse", 32'(prev_start), 0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_start", 32'(tx_start), 0);
            end else begin
                e  = exp_q.pop_front();
                oh = NUM_REQ'(1) << e.idx;
                check_eq("grant_idx", 32'(grant_idx), 32'(e.idx));
                check_eq("tx_data",   32'(tx_data),   32'(e.data));
                check_eq("ack",       32'(ack),       32'(oh));
                check_eq("busy_start", 32'(busy), 1);
            end
        end else if (ack != '0) begin
            check_eq("stray_ack", 32'(ack), 0);
        end
        prev_start = tx_start;
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) bytes[i] = 8'h00;
        m_ptr = 3'(NUM_REQ - 1);
        do_reset("rst0");

        // Single requester, gap length after tx_done falls.
        bytes[0] = 8'h41;
        req = 4'b0001;
        push_exp(req);
        wait_start(n);
        check_eq("t1_lat", 32'(n), 1);
        req = '0;
        xmit(2, 10);
        check_eq("t1_data_hold", 32'(tx_data), 'h41);
        check_eq("t1_busy_wait", 32'(busy), 1);
        wait_idle(n);
        check_eq("t1_gap", 32'(n), GAP_CYCLES + 1);

        // All four held: rotation 0,1,2,3,0.
        do_reset("rst2");
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30; bytes[3] = 8'h40;
        run_frames(4'b1111, 5, "t2");

        // Two held: alternation 0,2,0,2.
        do_reset("rst3");
        run_frames(4'b0101, 4, "t3");

        // Request arriving mid-frame waits out the gap.
        req = 4'b1000;
        push_exp(req);
        wait_start(n);
        check_eq("t4_lat", 32'(n), 1);
        req = '0;
        @(negedge clk);
        tx_done = 1'b1;
        repeat (2) @(negedge clk);
        req = 4'b0010;
        push_exp(req);
        repeat (2) @(negedge clk);
        tx_done = 1'b0;
        wait_start(n);
        check_eq("t4_spacing", 32'(n), GAP_CYCLES + 2);
        req = '0;
        xmit(1, 3);
        wait_idle(n);
        check_eq("t4_gap", 32'(n), GAP_CYCLES + 1);

        // Reset in the middle of WAIT_DONE.
        req = 4'b0100;
        push_exp(req);
        wait_start(n);
        req = '0;
        @(negedge clk);
        tx_done = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        tx_done = 1'b0;
        @(negedge clk);
        check_eq("t5_busy",  32'(busy), 0);
        check_eq("t5_ack",   32'(ack), 0);
        check_eq("t5_start", 32'(tx_start), 0);
        check_eq("t5_data",  32'(tx_data), 0);
        check_eq("t5_grant", 32'(grant_idx), 0);
        rst   = 1'b0;
        m_ptr = 3'(NUM_REQ - 1);
        req   = 4'b0010;
        push_exp(req);
        wait_start(n);
        check_eq("t5_lat", 32'(n), 1);
        req = '0;
        xmit(1, 3);
        wait_idle(n);
        check_eq("t5_gap", 32'(n), GAP_CYCLES + 1);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Transmitter never responds: watchdog fires, next frame still served.
        req = 4'b0001;
        push_exp(req);
        wait_start(n);
        req = '0;
        check_eq("t6_err_pre", 32'(err), 0);
        wait_idle(n);
        check_eq("t6_timeout", 32'(n), TIMEOUT_CYCLES + 1);
        check_eq("t6_err", 32'(err), 1);
        req = 4'b0100;
        push_exp(req);
        wait_start(n);
        check_eq("t6_lat", 32'(n), 1);
        req = '0;
        xmit(1, 3);
        wait_idle(n);
        check_eq("t6_gap", 32'(n), GAP_CYCLES + 1);
        check_eq("t6_err_sticky", 32'(err), 1);
`else
        check_eq("err_tied", 32'(err), 0);
`endif

        check_eq("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
